// File: rtl/drop_controller_if.sv
// Handshake bundle between the player-input side and the drop controller.
// The slave modport is the controller's view; i_* are driven into it, o_* come out of it.
interface drop_controller_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16
);
   localparam int CW = $clog2(COLS);
   localparam int MW = $clog2(ROWS*COLS+1);

   logic [CW-1:0]   i_col_sel;
   logic            i_drop;
   logic            i_step_en;
   logic [COLS-1:0] o_inject_col;
   logic            o_inject_g;
   logic            o_inject_r;
   logic            o_player;
   logic            o_busy;
   logic [COLS-1:0] o_col_full;
   logic            o_board_full;
   logic [MW-1:0]   o_moves;
   logic            o_reject;

   modport slave (
      input  i_col_sel, i_drop, i_step_en,
      output o_inject_col, o_inject_g, o_inject_r, o_player, o_busy,
             o_col_full, o_board_full, o_moves, o_reject
   );

   modport master (
      output i_col_sel, i_drop, i_step_en,
      input  o_inject_col, o_inject_g, o_inject_r, o_player, o_busy,
             o_col_full, o_board_full, o_moves, o_reject
   );
endinterface

// File: rtl/drop_controller.sv
// Connect-four style drop sequencer: accepts a column, injects a coloured piece into the
// top row, lets it fall at the step_en rate, then lands it and hands the move over.
module drop_controller #(
   parameter int ROWS = 16,
   parameter int COLS = 16
) (
   input logic              clk,
   input logic              rst_n,
   drop_controller_if.slave bus
);
   localparam int HW = $clog2(ROWS+1);
   localparam int CW = $clog2(COLS);
   localparam int MW = $clog2(ROWS*COLS+1);
   localparam logic [MW-1:0] TOTAL    = MW'(ROWS*COLS);
   localparam logic [HW-1:0] ROWS_H   = HW'(ROWS);
   localparam logic [HW-1:0] LAST_ROW = HW'(ROWS-1);

   typedef enum logic [2:0] {S_IDLE, S_INJECT, S_FALL, S_LAND, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cur_col;
   logic [HW-1:0]   r_fall_cnt;
   logic [MW-1:0]   r_moves;
   logic            r_player;
   logic            r_reject;
   logic [HW-1:0]   r_height [COLS];
   logic [COLS-1:0] w_col_full;
   logic [HW-1:0]   w_fall_load;
   logic            w_accept;
   logic            w_refuse;
   logic [COLS-1:0] w_inject_col;
   logic            w_inject_g;
   logic            w_inject_r;
   logic            w_busy;

   genvar gi;
   generate
      for (gi = 0; gi < COLS; gi++) begin : g_col_full
         assign w_col_full[gi] = (r_height[gi] == ROWS_H);
      end
   endgenerate

   // Rows left to traverse below the top row before the piece rests on the stack.
   assign w_fall_load = LAST_ROW - r_height[r_cur_col];
   assign w_accept    = (r_state == S_IDLE) && bus.i_drop && !w_col_full[bus.i_col_sel];
   assign w_refuse    = bus.i_drop &&
                        (((r_state == S_IDLE) && w_col_full[bus.i_col_sel]) || (r_state == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_inject_col = '0;
      w_inject_g   = 1'b0;
      w_inject_r   = 1'b0;
      w_busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_INJECT;
         end
         S_INJECT: begin
            w_inject_col = COLS'(1) << r_cur_col;
            w_inject_g   = r_player;
            w_inject_r   = ~r_player;
            w_state_next = (w_fall_load == '0) ? S_LAND : S_FALL;
         end
         S_FALL: begin
            if ((r_fall_cnt == '0) || (bus.i_step_en && (r_fall_cnt == HW'(1))))
               w_state_next = S_LAND;
         end
         S_LAND: begin
            w_state_next = ((r_moves + MW'(1)) == TOTAL) ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            w_state_next = S_DONE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_col  <= '0;
         r_fall_cnt <= '0;
         r_moves    <= '0;
         r_player   <= 1'b0;
         r_reject   <= 1'b0;
         for (int i = 0; i < COLS; i++) r_height[i] <= '0;
      end else begin
         r_reject <= w_refuse;
         if (w_accept) r_cur_col <= bus.i_col_sel;
         if (r_state == S_INJECT) r_fall_cnt <= w_fall_load;
         if ((r_state == S_FALL) && bus.i_step_en && (r_fall_cnt != '0))
            r_fall_cnt <= r_fall_cnt - HW'(1);
         if (r_state == S_LAND) begin
            r_moves              <= r_moves + MW'(1);
            r_player             <= ~r_player;
            r_height[r_cur_col]  <= r_height[r_cur_col] + HW'(1);
         end
      end
   end

   assign bus.o_inject_col = w_inject_col;
   assign bus.o_inject_g   = w_inject_g;
   assign bus.o_inject_r   = w_inject_r;
   assign bus.o_player     = r_player;
   assign bus.o_busy       = w_busy;
   assign bus.o_col_full   = w_col_full;
   assign bus.o_board_full = (r_moves == TOTAL);
   assign bus.o_moves      = r_moves;
   assign bus.o_reject     = r_reject;
endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller: single moves, fall timing, full-column refusal,
// mid-fall reset and a complete board fill.
module tb_drop_controller;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   drop_controller_if #(.ROWS(16), .COLS(16)) bus ();

   drop_controller #(.ROWS(16), .COLS(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_drop = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   // Drop into col; returns busy cycle count plus what was seen on the inject outputs.
   task automatic move(input int col, input bit slow, input bit drop_mid,
                       output int cycles, output logic [15:0] inj_col,
                       output logic inj_r, output logic inj_g, output int extra);
      bus.i_col_sel = 4'(col);
      bus.i_drop    = 1'b1;
      bus.i_step_en = 1'b1;
      tick();
      bus.i_drop = 1'b0;
      inj_col = bus.o_inject_col;
      inj_r   = bus.o_inject_r;
      inj_g   = bus.o_inject_g;
      cycles  = bus.o_busy ? 1 : 0;
      extra   = 0;
      for (int e = 1; e < 200; e++) begin
         bus.i_step_en = slow ? ((e % 4) == 0) : 1'b1;
         bus.i_drop    = drop_mid && (e == 5);
         tick();
         bus.i_drop = 1'b0;
         if (!bus.o_busy || bus.o_board_full) break;
         cycles++;
         if (bus.o_reject || (bus.o_inject_col != '0)) extra++;
      end
      bus.i_step_en = 1'b1;
   endtask

   int          cyc;
   int          ext;
   int          fill_err;
   logic [15:0] ic;
   logic        ir;
   logic        ig;

   initial begin
      total = 0;
      bad   = 0;
      bus.i_col_sel = '0;
      bus.i_drop    = 1'b0;
      bus.i_step_en = 1'b1;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy",       32'(bus.o_busy),       32'd0);
      chk("rst_reject",     32'(bus.o_reject),     32'd0);
      chk("rst_inject_col", 32'(bus.o_inject_col), 32'd0);
      chk("rst_inject_rg",  32'({bus.o_inject_r, bus.o_inject_g}), 32'd0);
      chk("rst_col_full",   32'(bus.o_col_full),   32'd0);
      chk("rst_board_full", 32'(bus.o_board_full), 32'd0);
      chk("rst_moves",      32'(bus.o_moves),      32'd0);
      chk("rst_player",     32'(bus.o_player),     32'd0);
      tick();
      rst_n = 1'b1;

      // First red piece, empty column 5: INJECT + 15 FALL + LAND.
      move(5, 1'b0, 1'b0, cyc, ic, ir, ig, ext);
      chk("m1_inject_col", 32'(ic), 32'h0020);
      chk("m1_inject_rg",  32'({ir, ig}), 32'b10);
      chk("m1_cycles",     32'(cyc), 32'd17);
      chk("m1_moves",      32'(bus.o_moves), 32'd1);
      chk("m1_player",     32'(bus.o_player), 32'd1);
      chk("m1_idle_inj",   32'(bus.o_inject_col), 32'd0);

      // Green on top of it: one row shorter fall.
      move(5, 1'b0, 1'b0, cyc, ic, ir, ig, ext);
      chk("m2_inject_rg",  32'({ir, ig}), 32'b01);
      chk("m2_cycles",     32'(cyc), 32'd16);
      chk("m2_player",     32'(bus.o_player), 32'd0);

      // step_en 1-in-4: 15 pulses needed, last on the 60th edge after INJECT.
      move(7, 1'b1, 1'b0, cyc, ic, ir, ig, ext);
      chk("slow_inject_col", 32'(ic), 32'h0080);
      chk("slow_cycles",     32'(cyc), 32'd61);
      chk("slow_moves",      32'(bus.o_moves), 32'd3);

      // A drop while falling is ignored.
      move(8, 1'b0, 1'b1, cyc, ic, ir, ig, ext);
      chk("midrop_cycles", 32'(cyc), 32'd17);
      chk("midrop_extra",  32'(ext), 32'd0);
      chk("midrop_moves",  32'(bus.o_moves), 32'd4);
      tick();
      chk("midrop_no_queue", 32'(bus.o_busy), 32'd0);

      // Asynchronous reset in the middle of a fall.
      bus.i_col_sel = 4'd9;
      bus.i_drop    = 1'b1;
      tick();
      bus.i_drop = 1'b0;
      repeat (8) tick();
      chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",   32'(bus.o_busy), 32'd0);
      chk("mid_rst_moves",  32'(bus.o_moves), 32'd0);
      chk("mid_rst_player", 32'(bus.o_player), 32'd0);
      chk("mid_rst_full",   32'(bus.o_col_full), 32'd0);
      tick();
      rst_n = 1'b1;
      move(9, 1'b0, 1'b0, cyc, ic, ir, ig, ext);
      chk("post_rst_cycles", 32'(cyc), 32'd17);
      chk("post_rst_inj_rg", 32'({ir, ig}), 32'b10);

      // Fill column 3 with alternating colours, then refuse a 17th piece.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         move(3, 1'b0, 1'b0, cyc, ic, ir, ig, ext);
         chk($sformatf("col3_move%0d_cycles", k), 32'(cyc), 32'(17 - k));
      end
      chk("col3_full",   32'(bus.o_col_full), 32'h0008);
      chk("col3_moves",  32'(bus.o_moves), 32'd16);
      chk("col3_player", 32'(bus.o_player), 32'd0);
      bus.i_col_sel = 4'd3;
      bus.i_drop    = 1'b1;
      tick();
      bus.i_drop = 1'b0;
      chk("rej_pulse",  32'(bus.o_reject), 32'd1);
      chk("rej_busy",   32'(bus.o_busy), 32'd0);
      chk("rej_inject", 32'(bus.o_inject_col), 32'd0);
      tick();
      chk("rej_one_cycle", 32'(bus.o_reject), 32'd0);
      chk("rej_moves",     32'(bus.o_moves), 32'd16);
      chk("rej_player",    32'(bus.o_player), 32'd0);

      // Fill the rest of the board; column 15 completes it.
      fill_err = 0;
      for (int c = 0; c < 16; c++) begin
         if (c != 3) begin
            for (int h = 0; h < 16; h++) begin
               move(c, 1'b0, 1'b0, cyc, ic, ir, ig, ext);
               if (cyc != 17 - h) fill_err++;
            end
         end
      end
      chk("fill_timing",    32'(fill_err), 32'd0);
      chk("full_board",     32'(bus.o_board_full), 32'd1);
      chk("full_busy",      32'(bus.o_busy), 32'd1);
      chk("full_moves",     32'(bus.o_moves), 32'd256);
      chk("full_col_full",  32'(bus.o_col_full), 32'hFFFF);
      bus.i_col_sel = 4'd0;
      bus.i_drop    = 1'b1;
      tick();
      bus.i_drop = 1'b0;
      chk("done_reject",  32'(bus.o_reject), 32'd1);
      chk("done_inject",  32'(bus.o_inject_col), 32'd0);
      repeat (3) tick();
      chk("done_stays",   32'(bus.o_busy), 32'd1);
      chk("done_rej_end", 32'(bus.o_reject), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
